// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM states, default bus widths, response codes.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam int unsigned APB_ADDWIDTH  = 8;
  localparam int unsigned APB_DATAWIDTH = 32;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired flags that the current wait cycle is the last one allowed.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired is set one edge early so the abort decision is taken on the TIMEOUT-th wait edge
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= (TIMEOUT == 1);
    end else if (enable) begin
      if (32'(cnt) < TIMEOUT) begin
        cnt <= cnt + CW'(1);
      end
      expired <= ((32'(cnt) + 32'd1) >= (TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: single-beat valid/ready commands to SETUP/ACCESS transfers on one of NSLV responders.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDWIDTH  = APB_ADDWIDTH,
  parameter int unsigned DATAWIDTH = APB_DATAWIDTH,
  parameter int unsigned NSLV      = 2,
  parameter int unsigned SW        = (NSLV > 1) ? $clog2(NSLV) : 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SW-1:0]             cmd_slv,
  input  logic [ADDWIDTH-1:0]       cmd_addr,
  input  logic [DATAWIDTH-1:0]      cmd_wdata,
  input  logic [DATAWIDTH/8-1:0]    cmd_strb,
  output logic                      rsp_valid,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic [NSLV-1:0]           PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDWIDTH-1:0]       PADDR,
  output logic [DATAWIDTH-1:0]      PWDATA,
  output logic [DATAWIDTH/8-1:0]    PSTRB,
  input  logic [NSLV-1:0]           PREADY,
  input  logic [NSLV*DATAWIDTH-1:0] PRDATA
);

  localparam int unsigned STRBW = DATAWIDTH / 8;

  apb_state_e           state_q, state_d;
  logic [SW-1:0]        slv_q, slv_d;

  logic                 cmd_ready_d;
  logic                 rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rdata_d;
  logic                 rsp_err_d;
  logic [NSLV-1:0]      psel_d;
  logic                 penable_d;
  logic                 pwrite_d;
  logic [ADDWIDTH-1:0]  paddr_d;
  logic [DATAWIDTH-1:0] pwdata_d;
  logic [STRBW-1:0]     pstrb_d;

  logic                 pready_sel;
  logic [DATAWIDTH-1:0] prdata_sel;
  logic [NSLV-1:0]      sel_onehot;
  logic                 slv_ok;
  logic                 accept;
  logic                 wait_clear;
  logic                 wait_en;
  logic                 wait_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  // Responder select decode for the incoming command and ready/data mux for the active one
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    sel_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (SW'(i) == slv_q) begin
        pready_sel = PREADY[i];
        prdata_sel = PRDATA[i*DATAWIDTH +: DATAWIDTH];
      end
      if (SW'(i) == cmd_slv) begin
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign slv_ok     = (32'(cmd_slv) < NSLV);
  assign accept     = cmd_valid && cmd_ready;
  assign wait_clear = (state_q != ST_ACCESS);
  assign wait_en    = (state_q == ST_ACCESS) && !pready_sel;

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_d     = state_q;
    slv_d       = slv_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = RSP_OK;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (slv_ok) begin
            state_d  = ST_SETUP;
            slv_d    = cmd_slv;
            psel_d   = sel_onehot;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_write ? cmd_strb : '0;
          end else begin
            // Unreachable responder: answer with an error, no bus activity
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_ERR;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (pready_sel || wait_expired) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
          if (pready_sel) begin
            rsp_rdata_d = PWRITE ? '0 : prdata_sel;
          end else begin
            rsp_err_d = RSP_ERR;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, command and output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      slv_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
    end else begin
      state_q   <= state_d;
      slv_q     <= slv_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a byte-strobed memory responder, a never-ready responder and a response scoreboard.
module tb_apb_master;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_slv;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [1:0]  PREADY;
  logic [63:0] PRDATA;

  apb_master #(
    .ADDWIDTH  (8),
    .DATAWIDTH (32),
    .NSLV      (2),
    .SW        (2),
    .TIMEOUT   (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_slv   (cmd_slv),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder 0: byte-strobed memory with a programmable number of wait states
  logic [31:0] mem0 [256];
  int          wcnt0 = 0;
  int          waits0 = 0;
  logic        rdy_force0 = 1'b0;
  logic        rdy_force1 = 1'b0;
  logic        acc0;

  assign acc0          = PSEL[0] && PENABLE;
  assign PREADY[0]     = rdy_force0 | (acc0 && (wcnt0 >= waits0));
  assign PREADY[1]     = rdy_force1;
  assign PRDATA[31:0]  = mem0[PADDR];
  assign PRDATA[63:32] = 32'hBAD0_BAD0;

  always @(posedge PCLK) begin
    if (acc0 && PREADY[0]) begin
      wcnt0 <= 0;
      if (PWRITE) begin
        for (int b = 0; b < 4; b++) begin
          if (PSTRB[b]) mem0[PADDR][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
    end else if (acc0) begin
      wcnt0 <= wcnt0 + 1;
    end else begin
      wcnt0 <= 0;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // Response monitor: every rsp_valid pulse must match the oldest expected response
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESET && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge inside the cycle after the accept edge
  task automatic issue(input logic wr, input logic [1:0] slv, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] erd, input logic eerr, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("cmd_ready_before_issue", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_slv   = slv;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;
    e.rdata = erd;
    e.err   = eerr;
    e.cyc   = cyc + 1 + lat;
    exp_q.push_back(e);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("wait_idle", 64'(cmd_ready), 64'h1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'h0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'h0);
    chk({tag, "_psel"},      64'(PSEL),      64'h0);
    chk({tag, "_penable"},   64'(PENABLE),   64'h0);
    chk({tag, "_pwrite"},    64'(PWRITE),    64'h0);
    chk({tag, "_paddr"},     64'(PADDR),     64'h0);
    chk({tag, "_pwdata"},    64'(PWDATA),    64'h0);
    chk({tag, "_pstrb"},     64'(PSTRB),     64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem0[a] = 32'h0;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_slv   = 2'd0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("ready_after_reset", 64'(cmd_ready), 64'h1);

    // Zero-wait write to responder 0
    waits0 = 0;
    issue(1'b1, 2'd0, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2);
    chk("wr_setup_psel", 64'(PSEL), 64'h1);
    chk("wr_setup_penable", 64'(PENABLE), 64'h0);
    chk("wr_setup_pwrite", 64'(PWRITE), 64'h1);
    chk("wr_setup_paddr", 64'(PADDR), 64'h10);
    chk("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    chk("wr_setup_pstrb", 64'(PSTRB), 64'hF);
    chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'h0);
    @(negedge PCLK);
    chk("wr_access_penable", 64'(PENABLE), 64'h1);
    chk("wr_access_psel", 64'(PSEL), 64'h1);
    @(negedge PCLK);
    chk("wr_done_psel", 64'(PSEL), 64'h0);
    chk("wr_done_penable", 64'(PENABLE), 64'h0);
    chk("wr_done_pstrb", 64'(PSTRB), 64'h0);
    chk("wr_done_paddr_hold", 64'(PADDR), 64'h10);
    chk("wr_done_cmd_ready", 64'(cmd_ready), 64'h0);
    @(negedge PCLK);
    chk("wr_e3_cmd_ready", 64'(cmd_ready), 64'h1);

    // Four-wait read from responder 0 while responder 1 holds PREADY high
    waits0 = 4;
    rdy_force1 = 1'b1;
    issue(1'b0, 2'd0, 8'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 6);
    chk("rd_setup_pstrb", 64'(PSTRB), 64'h0);
    chk("rd_setup_pwrite", 64'(PWRITE), 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK);
      chk("rd_access_penable", 64'(PENABLE), 64'h1);
      chk("rd_access_psel", 64'(PSEL), 64'h1);
      chk("rd_access_pstrb", 64'(PSTRB), 64'h0);
      chk("rd_access_rsp_rdata", 64'(rsp_rdata), 64'h0);
    end
    wait_idle();
    rdy_force1 = 1'b0;

    // Partial-strobe write, then read the merged word back
    waits0 = 0;
    issue(1'b1, 2'd0, 8'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 2);
    wait_idle();
    waits0 = 1;
    issue(1'b0, 2'd0, 8'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 3);
    wait_idle();

    // PREADY already high during SETUP must not shorten the transfer
    rdy_force0 = 1'b1;
    issue(1'b0, 2'd0, 8'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 2);
    chk("early_ready_setup_penable", 64'(PENABLE), 64'h0);
    @(negedge PCLK);
    chk("early_ready_access_penable", 64'(PENABLE), 64'h1);
    wait_idle();
    rdy_force0 = 1'b0;

    // Timeout on responder 1
    issue(1'b0, 2'd1, 8'h20, 32'h0, 4'h0, 32'h0, 1'b1, 17);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      chk("to_access_penable", 64'(PENABLE), 64'h1);
      chk("to_access_psel", 64'(PSEL), 64'h2);
    end
    @(negedge PCLK);
    chk("to_done_psel", 64'(PSEL), 64'h0);
    chk("to_done_penable", 64'(PENABLE), 64'h0);
    chk("to_done_cmd_ready", 64'(cmd_ready), 64'h0);
    @(negedge PCLK);
    chk("to_after_cmd_ready", 64'(cmd_ready), 64'h1);

    // Out-of-range responder index
    issue(1'b1, 2'd3, 8'h77, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 0);
    chk("bad_psel", 64'(PSEL), 64'h0);
    chk("bad_penable", 64'(PENABLE), 64'h0);
    chk("bad_paddr_hold", 64'(PADDR), 64'h20);
    chk("bad_pstrb", 64'(PSTRB), 64'h0);
    @(negedge PCLK);
    chk("bad_e1_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("bad_e1_psel", 64'(PSEL), 64'h0);

    // Reset in the middle of an ACCESS phase
    waits0 = 4;
    issue(1'b0, 2'd0, 8'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 6);
    @(negedge PCLK);
    chk("pre_reset_penable", 64'(PENABLE), 64'h1);
    PRESET = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("midreset_ready", 64'(cmd_ready), 64'h1);
    repeat (6) @(negedge PCLK);

    // Normal traffic after the mid-transfer reset
    waits0 = 0;
    issue(1'b1, 2'd0, 8'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 2);
    wait_idle();
    waits0 = 2;
    issue(1'b0, 2'd0, 8'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
    wait_idle();

    repeat (3) @(negedge PCLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
